lfsr_gen: RTL
=============

Name: lfsr_gen

Overview:
Parametrised successor to the team's 8-bit shift-left LFSR.
- Width is configurable, with Fibonacci or Galois form.
- Advances a configurable number of steps per accepted word.
- Output is a valid/ready word stream rather than a free-running state.
- Adds zero-state lockup recovery and period detection (the state returning to the loaded seed).
- Sits between the test-pattern/scrambler controllers and their consumers.

Parameters:
W, 8, state/word width (2..32)
STEPS, 1, LFSR steps applied per accepted transfer (1..W)
GALOIS, 0, 0 = Fibonacci (parity feedback into bit 0), 1 = Galois (bit W-1 XORs taps into shifted state)
DEFAULT_SEED, 1, non-zero state loaded at reset and on lockup recovery
CNT_W, 16, width of step counter and period length

Ports:
clk  in  1  clock; all state changes on posedge
rst  in  1  asynchronous reset, active-high
init  in  1  load seed this cycle
init_state  in  W  seed value, sampled when init=1
taps  in  W  tap mask; must be held stable while en=1
en  in  1  generator enable
out_ready  in  1  consumer accepts the current word
out_valid  out  1  word on state_o is valid
state_o  out  W  current LFSR state (the output word)
lockup  out  1  one-cycle pulse: zero state replaced by DEFAULT_SEED
period_done  out  1  one-cycle pulse: state returned to the recorded seed
period_len  out  CNT_W  advances in the last completed period, saturating

Behaviour:
- Reset (async, active-high):
  - state=DEFAULT_SEED, seed_reg=DEFAULT_SEED, seeded=0, step_cnt=0.
  - period_len=0; out_valid=0; lockup=0; period_done=0.
- Single step, Fibonacci: next={s[W-2:0], ^(s & taps)}.
- Single step, Galois: next={s[W-2:0],1'b0} ^ (s[W-1] ? taps : 0).
- Advance function: the single step applied STEPS times, combinationally within one cycle.
- out_valid = seeded & en. Registered state only; no combinational path from out_ready to out_valid.
- Transfer = out_valid & out_ready. On transfer, state <= advance(state) on the next edge, so state_o shows the new word 1 cycle after the accepting edge.
- Init (priority over transfer in the same cycle):
  - state <= init_state; seed_reg <= init_state; seeded <= 1; step_cnt <= 0.
  - If init_state==0: load DEFAULT_SEED into both state and seed_reg instead, and pulse lockup.
- Lockup recovery: if advance(state)==0 on a transfer, load DEFAULT_SEED and pulse lockup next cycle. step_cnt is cleared and seed_reg <= DEFAULT_SEED.
- Step counter:
  - step_cnt increments by 1 per transfer and saturates at all-ones.
  - If advance(state)==seed_reg on a transfer: pulse period_done, period_len <= step_cnt+1 (saturating), step_cnt <= 0.
- Simultaneous lockup and period match: lockup wins; no period_done.
- en low: state holds, out_valid=0. Counters and seed are kept; en is not a restart.
- Reset mid-stream: immediate return to reset values and seeded=0. No word is valid until the next init.

Decomposition:
- Package lfsr_pkg holds:
  - lfsr_mode_e enum (LFSR_FIB, LFSR_GALOIS);
  - a parametrised step function;
  - the saturating-increment helper.
- Sub-module lfsr_step: combinational single-step, one instance per step via a generate loop STEPS deep.
- The top holds all registers and the handshake.

Test Plan:
1. W=8, Fibonacci, taps=8'hB8, init 8'h01, out_ready=1 → state_o sequence 02,04,08,11. After 255 transfers: period_done pulse, period_len=255.
2. W=8, Galois, taps=8'h1D, init 8'h01 → 02,04,08,10,20,40,80,1D. period_len=255 after the full period.
3. STEPS=2, Fibonacci, taps=8'hB8, init 8'h01 → first transfer gives 04, second gives 11. out_ready=0 for 3 cycles → state_o stays 11, out_valid stays 1.
4. Lockup cases:
   - init_state=8'h00 → state_o=01 and lockup pulses once.
   - taps=8'h00, init 8'h80, one transfer → state_o=01, lockup pulses, no period_done.
5. init and transfer asserted together with init_state=8'h5A → state_o=5A (init wins) and step_cnt=0.
6. rst asserted mid-stream with no clock edge → state_o=01 and out_valid=0 immediately. Stays invalid with en=1 until the next init.

Source files
------------

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared types and helpers for the lfsr_gen word generator
//
// Purpose: LFSR mode enum, a width-parametrised single-step function and a
// saturating increment. Both functions work on 32-bit containers with an
// explicit active width, so one function body serves every instance width
// from 2 to 32.
package lfsr_pkg;

    typedef enum logic {
        LFSR_FIB    = 1'b0,
        LFSR_GALOIS = 1'b1
    } lfsr_mode_e;

    localparam int LFSR_MAX_W = 32;

    // All-ones in the low w bits; 1<<32 wraps to 0 in 32 bits, hence the guard.
    function automatic logic [31:0] width_mask(input int w);
        return (w >= LFSR_MAX_W) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // One LFSR step on the low w bits of s. Bits above w-1 must be zero.
    function automatic logic [31:0] lfsr_step_fn(input logic [31:0] s,
                                                 input logic [31:0] taps,
                                                 input int          w,
                                                 input lfsr_mode_e  mode);
        logic [31:0] m;
        logic [31:0] shl;
        logic        msb;
        m   = width_mask(w);
        shl = (s << 1) & m;
        // m ^ (m >> 1) isolates bit w-1 without a variable-width index.
        msb = |(s & (m ^ (m >> 1)));
        if (mode == LFSR_FIB) begin
            return shl | {31'd0, ^(s & taps & m)};
        end
        return shl ^ (msb ? (taps & m) : 32'd0);
    endfunction

    // v + 1, holding at all-ones of the low w bits.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        return (v == width_mask(w)) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// rtl/lfsr_step.sv - combinational single LFSR step
//
// Purpose: applies one Fibonacci or Galois step to a W-bit state.
// Ports:
//   state_i  in  W  current state
//   taps_i   in  W  tap mask
//   state_o  out W  state after one step
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int         W    = 8,
    parameter lfsr_mode_e MODE = LFSR_FIB
) (
    input  logic [W-1:0] state_i,
    input  logic [W-1:0] taps_i,
    output logic [W-1:0] state_o
);

    assign state_o = W'(lfsr_step_fn(32'(state_i), 32'(taps_i), W, MODE));

endmodule

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - parametrised LFSR word generator with valid/ready output
//
// Purpose: holds the LFSR state, seed, step counter and period length; emits
// the state as a word stream and advances STEPS steps per accepted word.
// Ports:
//   clk          in  1      clock
//   rst          in  1      asynchronous reset, active-high
//   init         in  1      load init_state (wins over a transfer)
//   init_state   in  W      seed; zero is replaced by DEFAULT_SEED
//   taps         in  W      tap mask, stable while en=1
//   en           in  1      generator enable
//   out_ready    in  1      consumer accepts the current word
//   out_valid    out 1      seeded & en
//   state_o      out W      current word
//   lockup       out 1      pulse: zero state replaced by DEFAULT_SEED
//   period_done  out 1      pulse: state returned to the recorded seed
//   period_len   out CNT_W  transfers in the last completed period
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int             W            = 8,
    parameter int             STEPS        = 1,
    parameter bit             GALOIS       = 1'b0,
    parameter logic [W-1:0]   DEFAULT_SEED = W'(1),
    parameter int             CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic [W-1:0]     init_state,
    input  logic [W-1:0]     taps,
    input  logic             en,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [W-1:0]     state_o,
    output logic             lockup,
    output logic             period_done,
    output logic [CNT_W-1:0] period_len
);

    localparam lfsr_mode_e MODE = GALOIS ? LFSR_GALOIS : LFSR_FIB;

    logic [W-1:0]     state_q;
    logic [W-1:0]     seed_q;
    logic             seeded_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] period_len_q;
    logic             lockup_q;
    logic             done_q;

    logic [STEPS:0][W-1:0] chain;
    logic [W-1:0]          adv_d;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  xfer;

    // STEPS single-step stages chained so a whole advance settles in one cycle.
    assign chain[0] = state_q;
    for (genvar g = 0; g < STEPS; g++) begin : g_step
        lfsr_step #(
            .W    (W),
            .MODE (MODE)
        ) u_step (
            .state_i (chain[g]),
            .taps_i  (taps),
            .state_o (chain[g+1])
        );
    end
    assign adv_d = chain[STEPS];

    assign cnt_inc   = CNT_W'(sat_inc(32'(cnt_q), CNT_W));
    assign out_valid = seeded_q & en;
    assign xfer      = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= DEFAULT_SEED;
            seed_q       <= DEFAULT_SEED;
            seeded_q     <= 1'b0;
            cnt_q        <= '0;
            period_len_q <= '0;
            lockup_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            lockup_q <= 1'b0;
            done_q   <= 1'b0;
            if (init) begin
                seeded_q <= 1'b1;
                cnt_q    <= '0;
                if (init_state == '0) begin
                    state_q  <= DEFAULT_SEED;
                    seed_q   <= DEFAULT_SEED;
                    lockup_q <= 1'b1;
                end else begin
                    state_q <= init_state;
                    seed_q  <= init_state;
                end
            end else if (xfer) begin
                if (adv_d == '0) begin
                    // Lockup recovery takes precedence over a period match.
                    state_q  <= DEFAULT_SEED;
                    seed_q   <= DEFAULT_SEED;
                    cnt_q    <= '0;
                    lockup_q <= 1'b1;
                end else begin
                    state_q <= adv_d;
                    if (adv_d == seed_q) begin
                        done_q       <= 1'b1;
                        period_len_q <= cnt_inc;
                        cnt_q        <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
            end
        end
    end

    assign state_o     = state_q;
    assign lockup      = lockup_q;
    assign period_done = done_q;
    assign period_len  = period_len_q;

endmodule
